seg7_display_arbiter: RTL and testbench

//  Shares the single 8-digit 7-seg display between NUM_REQ frame sources (key

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_scanner.sv | 51 +++++
 rtl/seg7_display_arbiter.sv | 168 ++++++++++++++++
 tb/tb_seg7_display_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment types and constants for the display arbiter slice.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef struct packed {
    logic [7:0][6:0] seg;
    logic [7:0]      dp;
  } seg7_frame_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    SWITCH = 2'd2
  } arb_state_t;

  localparam seg7_frame_t FRAME_BLANK = '{seg: {8{SEG_BLANK}}, dp: 8'hFF};

  // Active-low one-hot anode pattern for a digit position.
  function automatic logic [7:0] an_for_digit(input logic [2:0] digit);
    return ~(8'h01 << digit);
  endfunction

endpackage

// File: rtl/seg7_scanner.sv
// Free-running digit scanner: turns a frame register into multiplexed,
// registered SEG/AN/DP pins, forcing all-off while blank is high.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  seg7_frame_t frame,
  input  logic        blank,
  output logic [6:0]  SEG,
  output logic [7:0]  AN,
  output logic        DP
);

  logic [SCAN_BITS-1:0] cnt_q;
  logic [2:0]           digit_sel_s;
  logic [6:0]           seg_q;
  logic [7:0]           an_q;
  logic                 dp_q;

  assign digit_sel_s = cnt_q[SCAN_BITS-1 -: 3];

  // Scan counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + SCAN_BITS'(1);
    end
  end

  // Pin registers.
  always_ff @(posedge clk) begin
    if (rst || blank) begin
      seg_q <= SEG_BLANK;
      an_q  <= 8'hFF;
      dp_q  <= 1'b1;
    end else begin
      seg_q <= frame.seg[digit_sel_s];
      an_q  <= an_for_digit(digit_sel_s);
      dp_q  <= frame.dp[digit_sel_s];
    end
  end

  assign SEG = seg_q;
  assign AN  = an_q;
  assign DP  = dp_q;

endmodule

// File: rtl/seg7_display_arbiter.sv
// Fixed-priority owner arbitration for the shared 8-digit display, with a
// minimum hold time and a blank gap between owners.
module seg7_display_arbiter
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MIN_HOLD     = 5000000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned SCAN_BITS    = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*56-1:0]      req_seg,
  input  logic [NUM_REQ*8-1:0]       req_dp,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       owner_valid,
  output logic [$clog2(NUM_REQ)-1:0] owner_id,
  output logic [6:0]                 SEG,
  output logic [7:0]                 AN,
  output logic                       DP
);

  localparam int unsigned OW = $clog2(NUM_REQ);
  localparam int unsigned HW = $clog2(MIN_HOLD + 1);
  localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MIN_HOLD);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  arb_state_t        state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [BW-1:0]     blank_q, blank_d;
  seg7_frame_t       frame_q, frame_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic              owner_valid_q, owner_valid_d;
  logic [OW-1:0]     owner_id_q, owner_id_d;

  seg7_frame_t       req_frame_s [NUM_REQ];
  logic [OW-1:0]     pick_s;
  logic              pick_valid_s;
  logic              req_owner_s;
  logic              leave_s;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_frame
    assign req_frame_s[i] = {req_seg[i*56 +: 56], req_dp[i*8 +: 8]};
  end

  // Lowest-index active request wins.
  always_comb begin
    pick_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pick_s = req[i] ? OW'(i) : pick_s;
    end
  end

  assign pick_valid_s = |req;
  assign req_owner_s  = req[owner_q];
  assign leave_s      = (hold_q == HOLD_MAX) && (!req_owner_s || (pick_s < owner_q));

  // Arbiter next-state, counters, frame register and status outputs.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    blank_d = blank_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          state_d = SHOW;
          owner_d = pick_s;
          hold_d  = '0;
          frame_d = req_frame_s[pick_s];
        end else begin
          frame_d = FRAME_BLANK;
        end
      end
      SHOW: begin
        if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HW'(1);
        end else begin
          hold_d = hold_q;
        end
        // A dropped owner keeps showing its last frame.
        if (req_owner_s) begin
          frame_d = req_frame_s[owner_q];
        end else begin
          frame_d = frame_q;
        end
        if (leave_s) begin
          state_d = SWITCH;
          blank_d = '0;
        end else begin
          state_d = SHOW;
        end
      end
      SWITCH: begin
        if (blank_q == BLANK_LAST) begin
          if (pick_valid_s) begin
            state_d = SHOW;
            owner_d = pick_s;
            hold_d  = '0;
            frame_d = req_frame_s[pick_s];
          end else begin
            state_d = IDLE;
            frame_d = FRAME_BLANK;
          end
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        frame_d = FRAME_BLANK;
      end
    endcase

    owner_valid_d = (state_d == SHOW);
    if (owner_valid_d) begin
      grant_d    = NUM_REQ'(1) << owner_d;
      owner_id_d = owner_d;
    end else begin
      grant_d    = '0;
      owner_id_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      hold_q        <= '0;
      blank_q       <= '0;
      frame_q       <= FRAME_BLANK;
      grant_q       <= '0;
      owner_valid_q <= 1'b0;
      owner_id_q    <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      hold_q        <= hold_d;
      blank_q       <= blank_d;
      frame_q       <= frame_d;
      grant_q       <= grant_d;
      owner_valid_q <= owner_valid_d;
      owner_id_q    <= owner_id_d;
    end
  end

  assign grant       = grant_q;
  assign owner_valid = owner_valid_q;
  assign owner_id    = owner_id_q;

  seg7_scanner #(
    .SCAN_BITS(SCAN_BITS)
  ) u_scanner (
    .clk  (clk),
    .rst  (rst),
    .frame(frame_q),
    .blank(state_q == SWITCH),
    .SEG  (SEG),
    .AN   (AN),
    .DP   (DP)
  );

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Randomized and scenario bench for seg7_display_arbiter against an
// owner/age/gap reference model of the display sharing rules.
module tb_seg7_display_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int MIN_HOLD     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int SCAN_BITS    = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [223:0] req_seg;
  logic [31:0]  req_dp;
  logic [3:0]   grant;
  logic         owner_valid;
  logic [1:0]   owner_id;
  logic [6:0]   SEG;
  logic [7:0]   AN;
  logic         DP;

  always #5 clk = ~clk;

  seg7_display_arbiter #(
    .NUM_REQ(NUM_REQ), .MIN_HOLD(MIN_HOLD),
    .BLANK_CYCLES(BLANK_CYCLES), .SCAN_BITS(SCAN_BITS)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_seg(req_seg), .req_dp(req_dp),
    .grant(grant), .owner_valid(owner_valid), .owner_id(owner_id),
    .SEG(SEG), .AN(AN), .DP(DP)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the display, for how long, remaining gap, shown frame.
  int         m_owner = -1;
  int         m_age   = 0;
  int         m_gap   = 0;
  int         m_cyc   = 0;
  logic [6:0] m_seg [8];
  logic [7:0] m_dp    = 8'hFF;

  logic [22:0] exp_bus;
  wire  [22:0] act_bus = {grant, owner_valid, owner_id, SEG, AN, DP};

  function automatic int lowest(input logic [3:0] r);
    int p = -1;
    for (int i = 3; i >= 0; i--) if (r[i]) p = i;
    return p;
  endfunction

  task automatic load_frame(input int idx);
    for (int d = 0; d < 8; d++) m_seg[d] = req_seg[idx*56 + d*7 +: 7];
    m_dp = req_dp[idx*8 +: 8];
  endtask

  task automatic blank_frame();
    for (int d = 0; d < 8; d++) m_seg[d] = 7'h7F;
    m_dp = 8'hFF;
  endtask

  task automatic rand_frames();
    for (int k = 0; k < 7; k++) req_seg[k*32 +: 32] = $urandom();
    req_dp = $urandom();
  endtask

  // One clock: the model advances with the same inputs the DUT sees; outputs
  // are compared afterwards at the falling edge.
  task automatic tick();
    logic [6:0] es;
    logic [7:0] ea;
    logic       ed;
    int         pk;
    int         dig;
    @(posedge clk);
    pk = lowest(req);
    if (rst) begin
      es = 7'h7F; ea = 8'hFF; ed = 1'b1;
      m_owner = -1; m_age = 0; m_gap = 0; m_cyc = 0;
      blank_frame();
    end else begin
      dig = (m_cyc / 4) % 8;
      if (m_gap > 0) begin
        es = 7'h7F; ea = 8'hFF; ed = 1'b1;
      end else begin
        es = m_seg[dig]; ea = ~(8'h01 << dig); ed = m_dp[dig];
      end
      m_cyc++;
      if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) begin
          if (pk >= 0) begin m_owner = pk; m_age = 0; load_frame(pk); end
          else blank_frame();
        end
      end else if (m_owner < 0) begin
        if (pk >= 0) begin m_owner = pk; m_age = 0; load_frame(pk); end
        else blank_frame();
      end else begin
        if (req[m_owner]) load_frame(m_owner);
        if (m_age >= MIN_HOLD && (!req[m_owner] || pk < m_owner)) begin
          m_owner = -1;
          m_gap   = BLANK_CYCLES;
        end else begin
          m_age++;
        end
      end
    end
    exp_bus = {(m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000, m_owner >= 0,
               (m_owner >= 0) ? 2'(m_owner) : 2'b00, es, ea, ed};
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; rand_frames();
    tick(); tick();
    checks++;
    if ({AN, SEG, DP, grant} !== {8'hFF, 7'h7F, 1'b1, 4'b0000}) begin
      failures++; $display("FAIL reset_pins got=%h want=%h", {AN, SEG, DP, grant}, {8'hFF, 7'h7F, 1'b1, 4'b0000});
    end
    checks++;
    if ({owner_valid, owner_id} !== 3'b000) begin
      failures++; $display("FAIL reset_owner got=%b want=000", {owner_valid, owner_id});
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (act_bus !== exp_bus) begin failures++; $display("FAIL reset_model i=%0d act=%h exp=%h", i, act_bus, exp_bus); end
      checks++;
      if (AN !== ~(8'h01 << ((i / 4) % 8)) || SEG !== 7'h7F) begin
        failures++; $display("FAIL idle_scan i=%0d AN=%h SEG=%h", i, AN, SEG);
      end
    end
  endtask

  task automatic test_grant_from_idle();
    bit seen = 1'b0;
    req = 4'b0100; rand_frames();
    tick();
    checks++;
    if (act_bus !== exp_bus) begin failures++; $display("FAIL grant_model act=%h exp=%h", act_bus, exp_bus); end
    checks++;
    if (grant !== 4'b0100 || owner_id !== 2'd2 || owner_valid !== 1'b1) begin
      failures++; $display("FAIL grant_idle grant=%b id=%0d want 0100/2", grant, owner_id);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (act_bus !== exp_bus) begin failures++; $display("FAIL grant_model i=%0d act=%h exp=%h", i, act_bus, exp_bus); end
      if (AN === 8'h7F) begin
        seen = 1'b1;
        checks++;
        if ({SEG, DP} !== {req_seg[2*56 + 7*7 +: 7], req_dp[2*8 + 7]}) begin
          failures++; $display("FAIL digit7 got=%h want=%h", {SEG, DP}, {req_seg[2*56 + 7*7 +: 7], req_dp[2*8 + 7]});
        end
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL digit7_timeout got=0 want=1"); end
  endtask

  task automatic test_preempt();
    int n = 0;
    int nblank = 0;
    req = 4'b0000;
    while (!(m_owner < 0 && m_gap == 0) && n < 40) begin
      tick(); n++;
      checks++;
      if (act_bus !== exp_bus) begin failures++; $display("FAIL preempt_model act=%h exp=%h", act_bus, exp_bus); end
    end
    req = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (act_bus !== exp_bus) begin failures++; $display("FAIL preempt_model act=%h exp=%h", act_bus, exp_bus); end
    end
    req = 4'b0101; n = 0;
    while (grant !== 4'b0001 && n < 30) begin
      tick(); n++;
      if (AN === 8'hFF) nblank++;
      checks++;
      if (act_bus !== exp_bus) begin failures++; $display("FAIL preempt_model n=%0d act=%h exp=%h", n, act_bus, exp_bus); end
    end
    checks++;
    if (n != MIN_HOLD - 3 + 1 + BLANK_CYCLES) begin
      failures++; $display("FAIL preempt_latency got=%0d want=%0d", n, MIN_HOLD - 3 + 1 + BLANK_CYCLES);
    end
    checks++;
    if (nblank != BLANK_CYCLES) begin failures++; $display("FAIL preempt_blank got=%0d want=%0d", nblank, BLANK_CYCLES); end
  endtask

  task automatic test_no_preempt_lower();
    int n = 0;
    req = 4'b0010;
    while (grant !== 4'b0010 && n < 40) begin
      tick(); n++;
      checks++;
      if (act_bus !== exp_bus) begin failures++; $display("FAIL lower_model act=%h exp=%h", act_bus, exp_bus); end
    end
    req = 4'b1010;
    for (int i = 0; i < 20; i++) begin
      rand_frames(); tick();
      checks++;
      if (act_bus !== exp_bus) begin failures++; $display("FAIL lower_model i=%0d act=%h exp=%h", i, act_bus, exp_bus); end
      checks++;
      if (grant !== 4'b0010) begin failures++; $display("FAIL no_preempt i=%0d grant=%b want=0010", i, grant); end
    end
    req = 4'b1000; n = 0;
    while (grant !== 4'b1000 && n < 20) begin
      tick(); n++;
      checks++;
      if (act_bus !== exp_bus) begin failures++; $display("FAIL lower_model act=%h exp=%h", act_bus, exp_bus); end
    end
    checks++;
    if (n != 1 + BLANK_CYCLES) begin failures++; $display("FAIL release_latency got=%0d want=%0d", n, 1 + BLANK_CYCLES); end
  endtask

  task automatic test_drop_reraise();
    int n = 0;
    req = 4'b1001;
    while (grant !== 4'b0001 && n < 40) begin
      tick(); n++;
      checks++;
      if (act_bus !== exp_bus) begin failures++; $display("FAIL reraise_model act=%h exp=%h", act_bus, exp_bus); end
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 2) req = 4'b1000;
      if (i == 5) req = 4'b1001;
      rand_frames(); tick();
      checks++;
      if (act_bus !== exp_bus) begin failures++; $display("FAIL reraise_model i=%0d act=%h exp=%h", i, act_bus, exp_bus); end
      checks++;
      if (grant !== 4'b0001) begin failures++; $display("FAIL hold_through_drop i=%0d grant=%b want=0001", i, grant); end
    end
  endtask

  task automatic test_reset_in_switch();
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || owner_valid !== 1'b0) begin
      failures++; $display("FAIL enter_switch grant=%b valid=%b want 0000/0", grant, owner_valid);
    end
    rst = 1'b1; req = 4'b0001;
    tick();
    checks++;
    if ({grant, owner_valid, owner_id, AN, SEG, DP} !== {4'b0000, 1'b0, 2'b00, 8'hFF, 7'h7F, 1'b1}) begin
      failures++; $display("FAIL rst_in_switch got=%h want=%h", {grant, owner_valid, owner_id, AN, SEG, DP},
                           {4'b0000, 1'b0, 2'b00, 8'hFF, 7'h7F, 1'b1});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0001) begin failures++; $display("FAIL grant_after_rst got=%b want=0001", grant); end
    checks++;
    if (act_bus !== exp_bus) begin failures++; $display("FAIL rst_model act=%h exp=%h", act_bus, exp_bus); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3, 0) == 0) req = 4'($urandom_range(15, 0));
      rst = ($urandom_range(499, 0) == 0);
      rand_frames(); tick();
      checks++;
      if (act_bus !== exp_bus) begin failures++; $display("FAIL random i=%0d act=%h exp=%h", i, act_bus, exp_bus); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; req_seg = '0; req_dp = '0;
    blank_frame();
    test_reset();
    test_grant_from_idle();
    test_preempt();
    test_no_preempt_lower();
    test_drop_reraise();
    test_reset_in_switch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
